// File: rtl/safety_check_sched.sv
// safety_check_sched
// Time-multiplexed amplifier safety monitor for four axes. A single
// |current| > 2*|command| comparator is visited round-robin, one channel
// per clock, through a three-stage pipeline (sample, magnitude, compare).
// Each channel keeps a saturating count of consecutive failing visits.
// When the count reaches ERR_LIMIT the channel's amplifier-disable bit
// latches. A host clear handshake (IDLE -> CLEAR -> WAIT) releases the
// latched faults and counters of the masked channels.
//
// Optional build macro: SAFETY_DEADBAND_EN
//   When defined, a raw feedback current strictly inside (16'h7d00, 16'h8300)
//   counts as a pass. This keeps small-current noise from accumulating.
module safety_check_sched #(
    parameter int          NUM_CH    = 4,
    parameter logic [23:0] ERR_LIMIT = 24'd614400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] cur_in,
    input  logic [63:0] dac_in,
    input  logic [3:0]  ch_enable,
    input  logic        clr_req,
    input  logic [3:0]  clr_mask,
    output logic        clr_ack,
    output logic [3:0]  amp_disable,
    output logic        fault_any,
    input  logic [1:0]  err_cnt_sel,
    output logic [23:0] err_cnt
);

    localparam logic [15:0] MID_SCALE = 16'h7fff;
    localparam logic [23:0] CNT_MAX   = 24'hffffff;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WAIT  = 2'd2
    } clr_state_t;

    // Distance of an offset-binary sample from mid-scale
    function automatic logic [15:0] off_mag(input logic [15:0] v);
        off_mag = (v > MID_SCALE) ? (v - MID_SCALE) : (MID_SCALE - v);
    endfunction

    // Scheduler and pipeline registers
    logic [1:0]  scan_idx;
    logic        s0_valid;
    logic [1:0]  s0_idx;
    logic [15:0] s0_cur;
    logic [15:0] s0_dac;
    logic        s1_valid;
    logic [1:0]  s1_idx;
    logic [15:0] s1_abs_cur;
    logic [15:0] s1_abs_dac;
`ifdef SAFETY_DEADBAND_EN
    logic [15:0] s1_raw_cur;
`endif

    // Per-channel state
    logic [NUM_CH-1:0][23:0] cnt_reg;
    logic [NUM_CH-1:0][23:0] cnt_next;
    logic [NUM_CH-1:0]       amp_next;
    logic [NUM_CH-1:0]       s2_hit;

    // Clear handshake
    clr_state_t  state_reg;
    logic [3:0]  clr_mask_reg;
    logic        clear_fire;
    logic [3:0]  clear_vec;

    // Stage-2 decision signals
    logic        s2_fail;
    logic        s2_band_pass;

    // Round-robin scan, sample stage and magnitude stage. The scan never stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_idx   <= 2'd0;
            s0_valid   <= 1'b0;
            s0_idx     <= 2'd0;
            s0_cur     <= 16'd0;
            s0_dac     <= 16'd0;
            s1_valid   <= 1'b0;
            s1_idx     <= 2'd0;
            s1_abs_cur <= 16'd0;
            s1_abs_dac <= 16'd0;
`ifdef SAFETY_DEADBAND_EN
            s1_raw_cur <= 16'd0;
`endif
        end else begin
            scan_idx   <= scan_idx + 2'd1;
            s0_valid   <= 1'b1;
            s0_idx     <= scan_idx;
            s0_cur     <= cur_in[{scan_idx, 4'b0000} +: 16];
            s0_dac     <= dac_in[{scan_idx, 4'b0000} +: 16];
            s1_valid   <= s0_valid;
            s1_idx     <= s0_idx;
            s1_abs_cur <= off_mag(s0_cur);
            s1_abs_dac <= off_mag(s0_dac);
`ifdef SAFETY_DEADBAND_EN
            s1_raw_cur <= s0_cur;
`endif
        end
    end

    // Compare at 17 bits so that doubling the command magnitude never wraps
    assign s2_fail = {1'b0, s1_abs_cur} > {s1_abs_dac, 1'b0};

`ifdef SAFETY_DEADBAND_EN
    assign s2_band_pass = (s1_raw_cur > 16'h7d00) && (s1_raw_cur < 16'h8300);
`else
    assign s2_band_pass = 1'b0;
`endif

    // The clear applies on the edge that starts the CLEAR cycle. It uses the
    // live mask then, so the ack and the released disable bits appear together.
    // It is applied again during CLEAR with the captured mask.
    assign clear_fire = (state_reg == ST_IDLE) && clr_req;
    assign clear_vec  = clear_fire               ? clr_mask     :
                        (state_reg == ST_CLEAR)  ? clr_mask_reg : 4'b0000;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign s2_hit[gi] = s1_valid && (s1_idx == 2'(gi));

            // Priority: clear, then disabled, then deadband, then fail/pass.
            // A disabled channel is held at zero every cycle, not only on its visit.
            assign cnt_next[gi] =
                clear_vec[gi]          ? 24'd0        :
                !ch_enable[gi]         ? 24'd0        :
                !s2_hit[gi]            ? cnt_reg[gi]  :
                s2_band_pass           ? 24'd0        :
                !s2_fail               ? 24'd0        :
                (cnt_reg[gi] == CNT_MAX) ? cnt_reg[gi] : cnt_reg[gi] + 24'd1;

            // The latch looks at the stored count. It therefore rises one
            // cycle after the S2 write that reached the limit. A clear always wins.
            assign amp_next[gi] = clear_vec[gi] ? 1'b0
                                : (amp_disable[gi] | (cnt_reg[gi] >= ERR_LIMIT));
        end
    endgenerate

    // Counters, fault latches and the registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg     <= '0;
            amp_disable <= 4'b0000;
            fault_any   <= 1'b0;
            err_cnt     <= 24'd0;
        end else begin
            cnt_reg     <= cnt_next;
            amp_disable <= amp_next;
            fault_any   <= |amp_disable;
            err_cnt     <= cnt_reg[err_cnt_sel];
        end
    end

    // Clear handshake: one ack per request; a held request waits in WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            clr_mask_reg <= 4'b0000;
            clr_ack      <= 1'b0;
        end else begin
            clr_ack <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (clr_req) begin
                        clr_mask_reg <= clr_mask;
                        clr_ack      <= 1'b1;
                        state_reg    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!clr_req) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_safety_check_sched.sv
// tb_safety_check_sched
// Directed bench for safety_check_sched with ERR_LIMIT = 16.
// Edge numbering: E1 is the first rising edge after reset release. The
// outputs are sampled on the falling edge that follows Ek.
// Channel k is written at S2 on edges E(3 + k + 4m).
module tb_safety_check_sched;

    localparam logic [23:0] LIM = 24'd16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] cur_in;
    logic [63:0] dac_in;
    logic [3:0]  ch_enable;
    logic        clr_req;
    logic [3:0]  clr_mask;
    logic        clr_ack;
    logic [3:0]  amp_disable;
    logic        fault_any;
    logic [1:0]  err_cnt_sel;
    logic [23:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int ack_seen;

    safety_check_sched #(.NUM_CH(4), .ERR_LIMIT(LIM)) dut (
        .clk         (clk),
        .reset       (reset),
        .cur_in      (cur_in),
        .dac_in      (dac_in),
        .ch_enable   (ch_enable),
        .clr_req     (clr_req),
        .clr_mask    (clr_mask),
        .clr_ack     (clr_ack),
        .amp_disable (amp_disable),
        .fault_any   (fault_any),
        .err_cnt_sel (err_cnt_sel),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] cur, input logic [15:0] dac);
        cur_in[k*16 +: 16] = cur;
        dac_in[k*16 +: 16] = dac;
    endtask

    task automatic set_all(input logic [15:0] cur, input logic [15:0] dac);
        for (int k = 0; k < 4; k++) set_ch(k, cur, dac);
    endtask

    // Called on a falling edge. Reset is released on a falling edge.
    task automatic restart();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        edge_no = 0;
    endtask

    task automatic goto_edge(input int k);
        while (edge_no < k) begin
            @(negedge clk);
            edge_no++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        set_all(16'h7fff, 16'h7fff);
        ch_enable   = 4'hf;
        clr_req     = 1'b0;
        clr_mask    = 4'h0;
        err_cnt_sel = 2'd0;

        // Reset values while reset is held
        @(negedge clk);
        @(negedge clk);
        check_val("rst_amp", 32'(amp_disable), 32'h0);
        check_val("rst_fault_any", 32'(fault_any), 32'h0);
        check_val("rst_clr_ack", 32'(clr_ack), 32'h0);
        check_val("rst_err_cnt", 32'(err_cnt), 32'h0);

        // 1) Quiet inputs: nothing counts, nothing latches
        $display("phase idle: all channels at mid-scale for 1000 cycles");
        restart();
        for (int k = 1; k <= 1000; k++) begin
            goto_edge(k);
            check_val("idle_amp", 32'(amp_disable), 32'h0);
            check_val("idle_err_cnt", 32'(err_cnt), 32'h0);
            err_cnt_sel = 2'(k % 4);
        end

        // 2) Ch2 fault. abs_cur = 0x2001 > 2*0x0101. The 16th write is at E65.
        $display("phase ch2 fault: cur=a000 dac=8100");
        set_all(16'h7fff, 16'h7fff);
        set_ch(2, 16'ha000, 16'h8100);
        err_cnt_sel = 2'd2;
        restart();
        goto_edge(65);
        check_val("ch2_amp_e65", 32'(amp_disable), 32'h0);
        check_val("ch2_cnt_e65", 32'(err_cnt), 32'd15);
        goto_edge(66);
        check_val("ch2_amp_e66", 32'(amp_disable), 32'h4);
        check_val("ch2_fany_e66", 32'(fault_any), 32'h0);
        check_val("ch2_cnt_e66", 32'(err_cnt), 32'd16);
        goto_edge(67);
        check_val("ch2_fany_e67", 32'(fault_any), 32'h1);

        // 3) Clear sampled at E73, which coincides with a ch2 S2 write
        $display("phase clear: clr_mask=0100 held 10 cycles");
        goto_edge(72);
        clr_mask = 4'b0100;
        clr_req  = 1'b1;
        goto_edge(73);
        check_val("clr_ack_e73", 32'(clr_ack), 32'h1);
        check_val("clr_amp_e73", 32'(amp_disable), 32'h0);
        check_val("clr_cnt_e73", 32'(err_cnt), 32'd17);
        check_val("clr_fany_e73", 32'(fault_any), 32'h1);
        ack_seen = 0;
        for (int k = 74; k <= 82; k++) begin
            goto_edge(k);
            if (clr_ack) ack_seen++;
            if (k == 74) begin
                check_val("clr_cnt_e74", 32'(err_cnt), 32'd0);
                check_val("clr_fany_e74", 32'(fault_any), 32'h0);
            end
            if (k == 78) check_val("clr_cnt_e78", 32'(err_cnt), 32'd1);
        end
        check_val("clr_extra_acks", 32'(ack_seen), 32'd0);
        clr_req = 1'b0;
        goto_edge(137);
        check_val("refault_amp_e137", 32'(amp_disable), 32'h0);
        goto_edge(138);
        check_val("refault_amp_e138", 32'(amp_disable), 32'h4);

        // 4) Ch1 disabled: no fault. After re-enable it counts from zero.
        $display("phase enable: ch1 disabled then re-enabled");
        set_all(16'ha000, 16'h8100);
        ch_enable   = 4'b1101;
        err_cnt_sel = 2'd1;
        restart();
        goto_edge(80);
        check_val("en_amp_e80", 32'(amp_disable), 32'hd);
        check_val("en_cnt_e80", 32'(err_cnt), 32'd0);
        ch_enable = 4'hf;
        goto_edge(85);
        check_val("en_cnt_e85", 32'(err_cnt), 32'd1);
        goto_edge(89);
        check_val("en_cnt_e89", 32'(err_cnt), 32'd2);
        goto_edge(144);
        check_val("en_amp_e144", 32'(amp_disable), 32'hd);
        goto_edge(145);
        check_val("en_amp_e145", 32'(amp_disable), 32'hf);

        // 5) Small current on ch0, inside the optional deadband
        $display("phase deadband: ch0 cur=8200 dac=7fff");
        set_all(16'h7fff, 16'h7fff);
        set_ch(0, 16'h8200, 16'h7fff);
        err_cnt_sel = 2'd0;
        restart();
`ifdef SAFETY_DEADBAND_EN
        goto_edge(200);
        check_val("db_amp", 32'(amp_disable), 32'h0);
        check_val("db_cnt", 32'(err_cnt), 32'd0);
`else
        goto_edge(63);
        check_val("db_amp_e63", 32'(amp_disable), 32'h0);
        check_val("db_cnt_e63", 32'(err_cnt), 32'd15);
        goto_edge(64);
        check_val("db_amp_e64", 32'(amp_disable), 32'h1);
        check_val("db_cnt_e64", 32'(err_cnt), 32'd16);
`endif

        // 6) Reset asserted with ch3 count = 10 and the handshake in WAIT
        $display("phase reset mid-clear: ch3 count 10, handshake in WAIT");
        set_all(16'h7fff, 16'h7fff);
        set_ch(0, 16'ha000, 16'h8100);
        err_cnt_sel = 2'd3;
        restart();
        goto_edge(64);
        check_val("mid_amp_e64", 32'(amp_disable), 32'h1);
        set_ch(3, 16'ha000, 16'h8100);
        goto_edge(106);
        clr_mask = 4'b0010;
        clr_req  = 1'b1;
        goto_edge(107);
        check_val("mid_ack_e107", 32'(clr_ack), 32'h1);
        goto_edge(108);
        check_val("mid_ack_e108", 32'(clr_ack), 32'h0);
        check_val("mid_cnt_e108", 32'(err_cnt), 32'd10);
        check_val("mid_amp_e108", 32'(amp_disable), 32'h1);
        check_val("mid_fany_e108", 32'(fault_any), 32'h1);
        #2;
        reset   = 1'b0;
        clr_req = 1'b0;
        #1;
        check_val("async_amp", 32'(amp_disable), 32'h0);
        check_val("async_fany", 32'(fault_any), 32'h0);
        check_val("async_ack", 32'(clr_ack), 32'h0);
        check_val("async_cnt", 32'(err_cnt), 32'd0);
        set_all(16'h7fff, 16'h7fff);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        edge_no = 0;
        ack_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            goto_edge(k);
            if (clr_ack) ack_seen++;
        end
        check_val("post_rst_acks", 32'(ack_seen), 32'd0);
        check_val("post_rst_amp", 32'(amp_disable), 32'h0);
        check_val("post_rst_cnt", 32'(err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
